// File: rtl/board_redraw_sched.sv
// Incremental redraw scheduler for the 8x8 board: tracks map changes per tile and hands
// dirty tiles, round-robin, to the tile drawer. Optional watchdog: define DRAW_TIMEOUT_EN.
module board_redraw_sched
`ifdef DRAW_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = 300
)
`endif
(
   input  logic        clk,
   input  logic        resetn,
   input  logic [63:0] mineMap,
   input  logic [63:0] flagMap,
   input  logic [63:0] stepMap,
   input  logic [63:0] posMap,
   input  logic        full_redraw,
   input  logic        tile_done,
   output logic        tile_start,
   output logic [5:0]  tile_n,
   output logic        busy,
   output logic        frame_done,
   output logic        timeout_err,
   output logic [1:0]  dbg_state
);

   // Handshake: tile_start is high for exactly the START cycle; tile_n is held from then
   // until a tile_done is accepted in WAIT. tile_done in any other state is ignored.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_START = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] sh_mine_q, sh_mine_d, sh_flag_q, sh_flag_d;
   logic [63:0] sh_step_q, sh_step_d, sh_pos_q, sh_pos_d;
   logic [63:0] dirty_q, dirty_d;
   logic [63:0] chg, clr, rearm;
   logic [5:0]  ptr_q, ptr_d, tile_n_q, tile_n_d;
   logic        frame_done_q, frame_done_d;

`ifdef DRAW_TIMEOUT_EN
   localparam logic [8:0] WD_LAST = 9'(TIMEOUT_CYCLES - 1);
   logic [8:0] wd_q, wd_d;
   logic       timeout_err_q, timeout_err_d;
`endif

   assign chg = (mineMap ^ sh_mine_q) | (flagMap ^ sh_flag_q) |
                (stepMap ^ sh_step_q) | (posMap ^ sh_pos_q);

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      tile_n_d     = tile_n_q;
      frame_done_d = 1'b0;
      clr          = '0;
      rearm        = '0;
      sh_mine_d    = mineMap;
      sh_flag_d    = flagMap;
      sh_step_d    = stepMap;
      sh_pos_d     = posMap;
`ifdef DRAW_TIMEOUT_EN
      wd_d          = wd_q;
      timeout_err_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (dirty_q != '0) state_d = S_SCAN;
         end
         S_SCAN: begin
            if (dirty_q == '0) begin
               state_d      = S_IDLE;
               frame_done_d = 1'b1;
            end else if (dirty_q[ptr_q]) begin
               tile_n_d = ptr_q;
               state_d  = S_START;
            end else begin
               ptr_d = ptr_q + 6'd1;
            end
         end
         S_START: begin
            clr     = 64'd1 << tile_n_q;
            state_d = S_WAIT;
`ifdef DRAW_TIMEOUT_EN
            wd_d = '0;
`endif
         end
         S_WAIT: begin
            if (tile_done) begin
               ptr_d   = tile_n_q + 6'd1;
               state_d = S_SCAN;
            end
`ifdef DRAW_TIMEOUT_EN
            // Abandon the tile but keep it dirty so a later pass retries it.
            else if (wd_q == WD_LAST) begin
               rearm         = 64'd1 << tile_n_q;
               timeout_err_d = 1'b1;
               ptr_d         = tile_n_q + 6'd1;
               state_d       = S_SCAN;
            end else begin
               wd_d = wd_q + 9'd1;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
      // Set terms are OR-ed after the clear so a change during START is never lost.
      dirty_d = (dirty_q & ~clr) | chg | {64{full_redraw}} | rearm;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         sh_mine_q    <= '0;
         sh_flag_q    <= '0;
         sh_step_q    <= '0;
         sh_pos_q     <= '0;
         dirty_q      <= '1;
         ptr_q        <= '0;
         tile_n_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sh_mine_q    <= sh_mine_d;
         sh_flag_q    <= sh_flag_d;
         sh_step_q    <= sh_step_d;
         sh_pos_q     <= sh_pos_d;
         dirty_q      <= dirty_d;
         ptr_q        <= ptr_d;
         tile_n_q     <= tile_n_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef DRAW_TIMEOUT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wd_q          <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wd_q          <= wd_d;
         timeout_err_q <= timeout_err_d;
      end
   end
   assign timeout_err = timeout_err_q;
`else
   assign timeout_err = 1'b0;
`endif

   assign tile_start = (state_q == S_START);
   assign tile_n     = tile_n_q;
   assign busy       = (state_q != S_IDLE);
   assign frame_done = frame_done_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_board_redraw_sched.sv
// Self-checking bench for board_redraw_sched: drawer model, tile-order scoreboard and
// per-scenario tasks. Timeout scenario adapts to DRAW_TIMEOUT_EN.
module tb_board_redraw_sched;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd3;

   logic        clk = 1'b0;
   logic        resetn;
   logic [63:0] mineMap, flagMap, stepMap, posMap;
   logic        full_redraw;
   logic        tile_done = 1'b0;
   logic        tile_start;
   logic [5:0]  tile_n;
   logic        busy, frame_done, timeout_err;
   logic [1:0]  dbg_state;

   board_redraw_sched dut (
      .clk         (clk),
      .resetn      (resetn),
      .mineMap     (mineMap),
      .flagMap     (flagMap),
      .stepMap     (stepMap),
      .posMap      (posMap),
      .full_redraw (full_redraw),
      .tile_done   (tile_done),
      .tile_start  (tile_start),
      .tile_n      (tile_n),
      .busy        (busy),
      .frame_done  (frame_done),
      .timeout_err (timeout_err),
      .dbg_state   (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int tests_run = 0;
   int fails     = 0;
   logic [5:0] exp_q[$];
   int start_cnt = 0, frame_cnt = 0, timeout_cnt = 0;
   int cyc = 0, last_start_cyc = 0, last_to_cyc = 0;
   logic [5:0] cur_tile = '0;
   logic prev_wait = 1'b0;

   int drawer_lat = 266;
   logic hold_en = 1'b0;
   logic [5:0] hold_tile = '0;
   int kick_req = 0;
   int kick_ack = 0;
   int dr_cnt = 0;
   logic dr_active = 1'b0;

   // ---------------- drawer model ----------------
   always @(negedge clk) begin
      tile_done = 1'b0;
      if (!resetn) begin
         dr_active = 1'b0;
      end else if (kick_req != kick_ack) begin
         tile_done = 1'b1;
         kick_ack  = kick_req;
      end else if (tile_start) begin
         if (!(hold_en && tile_n == hold_tile)) begin
            dr_active = 1'b1;
            dr_cnt    = drawer_lat;
         end
      end else if (dr_active) begin
         dr_cnt = dr_cnt - 1;
         if (dr_cnt == 0) begin
            tile_done = 1'b1;
            dr_active = 1'b0;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [5:0] exp_t;
      cyc = cyc + 1;
      if (resetn) begin
         if (tile_start) begin
            start_cnt      = start_cnt + 1;
            last_start_cyc = cyc;
            cur_tile       = tile_n;
            tests_run      = tests_run + 1;
            if (exp_q.size() == 0) begin
               fails = fails + 1;
               $display("FAIL start_order: tile_start with tile_n=%0d, none expected", tile_n);
            end else begin
               exp_t = exp_q.pop_front();
               if (tile_n !== exp_t) begin
                  fails = fails + 1;
                  $display("FAIL start_order: tile_n=%0d expected %0d", tile_n, exp_t);
               end
            end
         end
         if (prev_wait && dbg_state != ST_WAIT) begin
            tests_run = tests_run + 1;
            if (tile_n !== cur_tile) begin
               fails = fails + 1;
               $display("FAIL tile_n_hold: tile_n=%0d expected %0d", tile_n, cur_tile);
            end
         end
         if (frame_done) begin
            frame_cnt = frame_cnt + 1;
            tests_run = tests_run + 1;
            if (busy !== 1'b0) begin
               fails = fails + 1;
               $display("FAIL frame_busy: busy=%b expected 0 with frame_done", busy);
            end
         end
         if (timeout_err) begin
            timeout_cnt = timeout_cnt + 1;
            last_to_cyc = cyc;
         end
         prev_wait = (dbg_state == ST_WAIT);
      end else begin
         prev_wait = 1'b0;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_frame(input int base, input int budget, input string name);
      int n = 0;
      while (frame_cnt <= base && n < budget) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (frame_cnt <= base) begin
         fails++;
         $display("FAIL %s: frame_done count=%0d, required >%0d within %0d cycles", name, frame_cnt, base, budget);
      end
   endtask

   task automatic wait_tile_wait(input logic [5:0] t, input string name);
      int n = 0;
      while (!(dbg_state == ST_WAIT && tile_n == t) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (!(dbg_state == ST_WAIT && tile_n == t)) begin
         fails++;
         $display("FAIL %s: state=%0d tile_n=%0d, required WAIT on tile %0d", name, dbg_state, tile_n, t);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests_run += 6;
      if (tile_start !== 1'b0) begin fails++; $display("FAIL reset_tile_start: got %b expected 0", tile_start); end
      if (tile_n !== 6'd0) begin fails++; $display("FAIL reset_tile_n: got %0d expected 0", tile_n); end
      if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
      if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
      if (timeout_err !== 1'b0) begin fails++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
      if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
   endtask

   task automatic test_power_up();
      int bs = start_cnt;
      int bf = frame_cnt;
      drawer_lat = 266;
      for (int i = 0; i < 64; i++) exp_q.push_back(6'(i));
      @(negedge clk);
      resetn = 1'b1;
      wait_frame(bf, 20000, "power_up_frame");
      repeat (4) @(negedge clk);
      tests_run += 4;
      if (exp_q.size() != 0) begin fails++; $display("FAIL power_up_queue: %0d tiles left, expected 0", exp_q.size()); end
      if (start_cnt - bs != 64) begin fails++; $display("FAIL power_up_starts: got %0d expected 64", start_cnt - bs); end
      if (frame_cnt - bf != 1) begin fails++; $display("FAIL power_up_frames: got %0d expected 1", frame_cnt - bf); end
      if (busy !== 1'b0) begin fails++; $display("FAIL power_up_busy: got %b expected 0", busy); end
   endtask

   task automatic test_single_change();
      int bs = start_cnt;
      int bf = frame_cnt;
      drawer_lat = $urandom_range(2, 12);
      exp_q.push_back(6'd9);
      @(negedge clk);
      stepMap[9] = ~stepMap[9];
      wait_frame(bf, 500, "single_frame");
      repeat (20) @(negedge clk);
      tests_run += 3;
      if (start_cnt - bs != 1) begin fails++; $display("FAIL single_starts: got %0d expected 1", start_cnt - bs); end
      if (frame_cnt - bf != 1) begin fails++; $display("FAIL single_frames: got %0d expected 1", frame_cnt - bf); end
      if (exp_q.size() != 0) begin fails++; $display("FAIL single_queue: %0d tiles left, expected 0", exp_q.size()); end
   endtask

   task automatic test_change_in_wait();
      int bs = start_cnt;
      int bf = frame_cnt;
      drawer_lat = 20;
      exp_q.push_back(6'd5);
      exp_q.push_back(6'd5);
      @(negedge clk);
      flagMap[5] = ~flagMap[5];
      wait_tile_wait(6'd5, "rewait_enter");
      flagMap[5] = ~flagMap[5];
      drawer_lat = $urandom_range(2, 8);
      wait_frame(bf, 1000, "rewait_frame");
      tests_run += 2;
      if (start_cnt - bs != 2) begin fails++; $display("FAIL rewait_starts: got %0d expected 2", start_cnt - bs); end
      if (exp_q.size() != 0) begin fails++; $display("FAIL rewait_queue: %0d tiles left, expected 0", exp_q.size()); end
   endtask

   task automatic test_round_robin();
      int bs = start_cnt;
      int bf;
      drawer_lat = $urandom_range(2, 8);
      exp_q.push_back(6'd9);
      @(negedge clk);
      mineMap[9] = ~mineMap[9];
      wait_frame(frame_cnt, 500, "rr_setup_frame");
      repeat (3) @(negedge clk);
      bf = frame_cnt;
      exp_q.push_back(6'd60);
      exp_q.push_back(6'd3);
      posMap[3]  = 1'b1;
      posMap[60] = 1'b1;
      wait_frame(bf, 1000, "rr_frame");
      tests_run += 2;
      if (start_cnt - bs != 3) begin fails++; $display("FAIL rr_starts: got %0d expected 3", start_cnt - bs); end
      if (exp_q.size() != 0) begin fails++; $display("FAIL rr_queue: %0d tiles left, expected 0", exp_q.size()); end
   endtask

   task automatic test_full_redraw();
      int bs = start_cnt;
      int bf = frame_cnt;
      drawer_lat = 30;
      exp_q.push_back(6'd20);
      @(negedge clk);
      mineMap[20] = ~mineMap[20];
      wait_tile_wait(6'd20, "full_enter");
      for (int i = 21; i < 64; i++) exp_q.push_back(6'(i));
      for (int i = 0; i <= 20; i++) exp_q.push_back(6'(i));
      drawer_lat  = $urandom_range(2, 6);
      full_redraw = 1'b1;
      @(negedge clk);
      full_redraw = 1'b0;
      wait_frame(bf, 5000, "full_frame");
      tests_run += 2;
      if (start_cnt - bs != 65) begin fails++; $display("FAIL full_starts: got %0d expected 65", start_cnt - bs); end
      if (exp_q.size() != 0) begin fails++; $display("FAIL full_queue: %0d tiles left, expected 0", exp_q.size()); end
   endtask

   task automatic test_timeout();
      int bs = start_cnt;
      int bf = frame_cnt;
      int bt = timeout_cnt;
      drawer_lat = $urandom_range(2, 6);
      hold_en    = 1'b1;
      hold_tile  = 6'd7;
`ifdef DRAW_TIMEOUT_EN
      begin
         int n = 0;
         exp_q.push_back(6'd7);
         exp_q.push_back(6'd7);
         @(negedge clk);
         mineMap[7] = ~mineMap[7];
         while (timeout_cnt == bt && n < 1000) begin
            @(negedge clk);
            n++;
         end
         hold_en = 1'b0;
         tests_run += 2;
         if (timeout_cnt == bt) begin
            fails++;
            $display("FAIL timeout_fire: timeout_err count=%0d, required a pulse", timeout_cnt - bt);
         end else if (last_to_cyc - last_start_cyc != 301) begin
            fails++;
            $display("FAIL timeout_fire: pulse %0d cycles after tile_start, expected 301", last_to_cyc - last_start_cyc);
         end
         wait_frame(bf, 1000, "timeout_frame");
         if (timeout_cnt - bt != 1) begin fails++; $display("FAIL timeout_count: got %0d expected 1", timeout_cnt - bt); end
         tests_run += 2;
         if (start_cnt - bs != 2) begin fails++; $display("FAIL timeout_starts: got %0d expected 2", start_cnt - bs); end
         if (exp_q.size() != 0) begin fails++; $display("FAIL timeout_queue: %0d tiles left, expected 0", exp_q.size()); end
      end
`else
      exp_q.push_back(6'd7);
      @(negedge clk);
      mineMap[7] = ~mineMap[7];
      repeat (350) @(negedge clk);
      tests_run += 3;
      if (timeout_cnt != bt) begin fails++; $display("FAIL notimeout_err: got %0d pulses expected 0", timeout_cnt - bt); end
      if (dbg_state !== ST_WAIT) begin fails++; $display("FAIL notimeout_state: got %0d expected 3", dbg_state); end
      if (busy !== 1'b1) begin fails++; $display("FAIL notimeout_busy: got %b expected 1", busy); end
      hold_en  = 1'b0;
      kick_req = kick_req + 1;
      wait_frame(bf, 500, "notimeout_frame");
      tests_run += 2;
      if (start_cnt - bs != 1) begin fails++; $display("FAIL notimeout_starts: got %0d expected 1", start_cnt - bs); end
      if (exp_q.size() != 0) begin fails++; $display("FAIL notimeout_queue: %0d tiles left, expected 0", exp_q.size()); end
`endif
   endtask

   task automatic test_async_reset();
      hold_en   = 1'b1;
      hold_tile = 6'd12;
      exp_q.push_back(6'd12);
      @(negedge clk);
      mineMap[12] = ~mineMap[12];
      wait_tile_wait(6'd12, "areset_enter");
      repeat (3) @(negedge clk);
      #3;
      resetn = 1'b0;
      #1;
      tests_run += 6;
      if (busy !== 1'b0) begin fails++; $display("FAIL areset_busy: got %b expected 0", busy); end
      if (tile_start !== 1'b0) begin fails++; $display("FAIL areset_tile_start: got %b expected 0", tile_start); end
      if (tile_n !== 6'd0) begin fails++; $display("FAIL areset_tile_n: got %0d expected 0", tile_n); end
      if (dbg_state !== ST_IDLE) begin fails++; $display("FAIL areset_state: got %0d expected 0", dbg_state); end
      if (frame_done !== 1'b0) begin fails++; $display("FAIL areset_frame_done: got %b expected 0", frame_done); end
      if (timeout_err !== 1'b0) begin fails++; $display("FAIL areset_timeout_err: got %b expected 0", timeout_err); end
      hold_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      resetn      = 1'b0;
      mineMap     = '0;
      flagMap     = '0;
      stepMap     = '0;
      posMap      = '0;
      full_redraw = 1'b0;
      test_reset();
      test_power_up();
      test_single_change();
      test_change_in_wait();
      test_round_robin();
      test_full_redraw();
      test_timeout();
      test_async_reset();
      tests_run++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL final_queue: %0d tiles never started, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
